axi_mem_responder: RTL and testbench
====================================

Name: axi_mem_responder

Overview:
- AXI4 slave memory that answers the 512-bit AXI4 master port driven by the PCIe DMA adapter.
- Backed by on-chip RAM; accepts INCR bursts on the write and read channels, which run independently.
- Used as the default DMA target in system builds and as the reference endpoint in DMA testbenches.

Parameters:
ADDR_WIDTH, 32, AXI address width
DATA_WIDTH, 512, AXI data width; fixed to 512 (64-byte beats, size code 3'b110)
MEM_DEPTH_LOG2, 10, log2 of RAM depth in 64-byte words (default 64 KB)

Ports:
s_axi_aclk  in  1  the block's single clock
s_axi_aresetn  in  1  synchronous active-low reset
s_axi_awaddr  in  ADDR_WIDTH  write burst start byte address
s_axi_awlen  in  8  write beats minus 1
s_axi_awsize  in  3  write beat size
s_axi_awburst  in  2  write burst type
s_axi_awlock/awcache/awprot/awregion/awqos  in  1/4/3/4/4  accepted, ignored
s_axi_awvalid  in  1  AW valid
s_axi_awready  out  1  AW ready
s_axi_wdata  in  512  write data
s_axi_wstrb  in  64  byte enables
s_axi_wlast  in  1  last write beat
s_axi_wvalid  in  1  W valid
s_axi_wready  out  1  W ready
s_axi_bresp  out  2  write response
s_axi_bvalid  out  1  B valid
s_axi_bready  in  1  B ready
s_axi_araddr/arlen/arsize/arburst  in  ADDR_WIDTH/8/3/2  read burst request
s_axi_arlock/arcache/arprot/arregion/arqos  in  1/4/3/4/4  accepted, ignored
s_axi_arvalid  in  1  AR valid
s_axi_arready  out  1  AR ready
s_axi_rdata  out  512  read data
s_axi_rresp  out  2  read response
s_axi_rlast  out  1  last read beat
s_axi_rvalid  out  1  R valid
s_axi_rready  in  1  R ready

Behaviour:

Reset and addressing:
- Reset: all outputs 0 except awready=1 and arready=1; both FSMs return to IDLE. RAM contents are not cleared.
- Word index = addr[6 +: MEM_DEPTH_LOG2]. Upper bits are ignored, so addresses alias modulo RAM size. addr[5:0] is ignored (beats are always aligned).
- Burst types:
  - INCR and WRAP: index increments by 1 per beat and wraps from the top of RAM to 0.
  - FIXED: index does not change.
- Error marking: size != 3'b110 or burst == 2'b11 marks the burst as an error.
  - Error write burst: no RAM writes; bresp = SLVERR (2'b10).
  - Error read burst: rdata = 0 and rresp = SLVERR on every beat.
  - Otherwise the response is OKAY (2'b00).

Write FSM (W_IDLE, W_DATA, W_RESP):
- W_IDLE: awready=1. On awvalid&awready, latch index/len/burst/err, clear the beat count and go to W_DATA.
- W_DATA: wready=1, awready=0. On each wvalid&wready, write the bytes with wstrb set (unset bytes keep old value), advance the index and increment the beat count.
  - Beats beyond awlen+1 are dropped (no write) and flag SLVERR.
  - The beat carrying wlast moves to W_RESP next cycle. If its count != awlen+1 (early or late wlast), bresp = SLVERR.
- W_RESP: bvalid=1, bresp held stable until bready. On bvalid&bready go to W_IDLE; awready=1 the following cycle.
- Write data is visible to reads starting the cycle after the W handshake.

Read FSM (R_IDLE, R_FETCH, R_DATA):
- R_IDLE: arready=1. On arvalid&arready at cycle T, latch the request and go to R_FETCH.
- R_FETCH: one-cycle synchronous RAM read; go to R_DATA.
- R_DATA: rvalid=1. rdata/rresp/rlast are held stable while rready=0. rlast=1 on beat arlen+1.
  - On rvalid&rready: if last, go to R_IDLE; otherwise advance the index and go to R_FETCH.
- Latency: first rvalid at T+2. Later beats are at least 2 cycles apart (peak 50% throughput). arready=0 outside R_IDLE.

Concurrency and reset:
- Read and write FSMs are fully independent.
- A same-cycle write and RAM read of the same word returns the old data (read-first).
- Reset mid-burst: the cycle after reset deassert, both FSMs are in IDLE and bvalid, rvalid, wready are 0. A partially written burst stays in RAM. The master must reissue.

Test Plan:
- Write-then-read: AW addr 0x0000_0040, len 3, INCR, 4 beats with data pattern k; B = OKAY. AR same address, len 3 -> 4 beats of pattern k, rlast only on beat 4, first rvalid exactly 2 cycles after AR handshake.
- Byte strobes: word 0 preloaded to all 0xFF; write 0 with wstrb = 64'h0000_0000_0000_00F0 -> read returns bytes 4..7 = 0x00, all other bytes 0xFF.
- Backpressure: 8-beat read with rready toggling 1-0-0-1 -> rdata/rlast stable while stalled, no beats lost or duplicated. bready held low 5 cycles -> bvalid stays 1, awready stays 0.
- Errors:
  - awsize 3'b101 -> no RAM change, bresp 2'b10.
  - wlast on beat 2 of len 3 -> bresp 2'b10.
  - arburst 2'b11 -> all beats rresp 2'b10, rdata 0.
- Wrap and FIXED: INCR write len 1 starting at the last RAM word -> second beat lands at index 0. FIXED write len 3 -> only the final beat's data remains at the start index.
- Reset mid-operation: assert s_axi_aresetn low during W_DATA beat 2 and R_DATA -> next cycle all valids 0, awready=arready=1; subsequent full transfers complete correctly.

Source files
------------

// File: rtl/axi_mem_responder.sv
// AXI4 512-bit slave memory: independent write/read FSMs over on-chip RAM.
// Read path is one beat per two cycles through a registered RAM read.
module axi_mem_responder #(
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 512,
  parameter int MEM_DEPTH_LOG2 = 10
) (
  input  logic                    s_axi_aclk,
  input  logic                    s_axi_aresetn,
  input  logic [ADDR_WIDTH-1:0]   s_axi_awaddr,
  input  logic [7:0]              s_axi_awlen,
  input  logic [2:0]              s_axi_awsize,
  input  logic [1:0]              s_axi_awburst,
  input  logic                    s_axi_awlock,
  input  logic [3:0]              s_axi_awcache,
  input  logic [2:0]              s_axi_awprot,
  input  logic [3:0]              s_axi_awregion,
  input  logic [3:0]              s_axi_awqos,
  input  logic                    s_axi_awvalid,
  output logic                    s_axi_awready,
  input  logic [DATA_WIDTH-1:0]   s_axi_wdata,
  input  logic [DATA_WIDTH/8-1:0] s_axi_wstrb,
  input  logic                    s_axi_wlast,
  input  logic                    s_axi_wvalid,
  output logic                    s_axi_wready,
  output logic [1:0]              s_axi_bresp,
  output logic                    s_axi_bvalid,
  input  logic                    s_axi_bready,
  input  logic [ADDR_WIDTH-1:0]   s_axi_araddr,
  input  logic [7:0]              s_axi_arlen,
  input  logic [2:0]              s_axi_arsize,
  input  logic [1:0]              s_axi_arburst,
  input  logic                    s_axi_arlock,
  input  logic [3:0]              s_axi_arcache,
  input  logic [2:0]              s_axi_arprot,
  input  logic [3:0]              s_axi_arregion,
  input  logic [3:0]              s_axi_arqos,
  input  logic                    s_axi_arvalid,
  output logic                    s_axi_arready,
  output logic [DATA_WIDTH-1:0]   s_axi_rdata,
  output logic [1:0]              s_axi_rresp,
  output logic                    s_axi_rlast,
  output logic                    s_axi_rvalid,
  input  logic                    s_axi_rready
);

  localparam int NB    = DATA_WIDTH / 8;
  localparam int DEPTH = 1 << MEM_DEPTH_LOG2;
  localparam int IW    = MEM_DEPTH_LOG2;

  localparam logic [1:0] W_IDLE  = 2'd0;
  localparam logic [1:0] W_DATA  = 2'd1;
  localparam logic [1:0] W_RESP  = 2'd2;
  localparam logic [1:0] R_IDLE  = 2'd0;
  localparam logic [1:0] R_FETCH = 2'd1;
  localparam logic [1:0] R_DATA  = 2'd2;

  localparam logic [2:0] SIZE_64B    = 3'b110;
  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_RSVD  = 2'b11;
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  logic [1:0]    w_state;
  logic [IW-1:0] w_idx;
  logic [7:0]    w_len;
  logic          w_fixed;
  logic          w_err;
  logic [8:0]    w_cnt;
  logic          w_hs;
  logic          w_in_range;
  logic          w_last_ok;
  logic          w_we;

  logic [1:0]            r_state;
  logic [IW-1:0]         r_idx;
  logic [7:0]            r_len;
  logic                  r_fixed;
  logic                  r_err;
  logic [7:0]            r_cnt;
  logic [DATA_WIDTH-1:0] r_data;

  assign w_hs       = (w_state == W_DATA) && s_axi_wvalid;
  assign w_in_range = w_cnt <= {1'b0, w_len};
  assign w_last_ok  = w_cnt == {1'b0, w_len};
  assign w_we       = w_hs && w_in_range && !w_err && s_axi_aresetn;

  always_ff @(posedge s_axi_aclk) begin
    if (!s_axi_aresetn) begin
      w_state <= W_IDLE;
      w_idx   <= '0;
      w_len   <= '0;
      w_fixed <= 1'b0;
      w_err   <= 1'b0;
      w_cnt   <= '0;
    end else begin
      unique case (w_state)
        W_IDLE: begin
          if (s_axi_awvalid) begin
            w_idx   <= s_axi_awaddr[6 +: IW];
            w_len   <= s_axi_awlen;
            w_fixed <= s_axi_awburst == BURST_FIXED;
            w_err   <= (s_axi_awsize != SIZE_64B) ||
                       (s_axi_awburst == BURST_RSVD);
            w_cnt   <= '0;
            w_state <= W_DATA;
          end
        end
        W_DATA: begin
          if (s_axi_wvalid) begin
            if (!w_fixed) w_idx <= w_idx + 1'b1;
            if (w_cnt != '1) w_cnt <= w_cnt + 1'b1;
            // overflow beats and a misplaced wlast both poison the burst
            if (!w_in_range || (s_axi_wlast && !w_last_ok))
              w_err <= 1'b1;
            if (s_axi_wlast) w_state <= W_RESP;
          end
        end
        W_RESP: begin
          if (s_axi_bready) w_state <= W_IDLE;
        end
        default: w_state <= W_IDLE;
      endcase
    end
  end

  always_ff @(posedge s_axi_aclk) begin
    if (w_we) begin
      for (int b = 0; b < NB; b++) begin
        if (s_axi_wstrb[b])
          mem[w_idx][8*b +: 8] <= s_axi_wdata[8*b +: 8];
      end
    end
  end

  always_ff @(posedge s_axi_aclk) begin
    if (!s_axi_aresetn) begin
      r_state <= R_IDLE;
      r_idx   <= '0;
      r_len   <= '0;
      r_fixed <= 1'b0;
      r_err   <= 1'b0;
      r_cnt   <= '0;
      r_data  <= '0;
    end else begin
      unique case (r_state)
        R_IDLE: begin
          if (s_axi_arvalid) begin
            r_idx   <= s_axi_araddr[6 +: IW];
            r_len   <= s_axi_arlen;
            r_fixed <= s_axi_arburst == BURST_FIXED;
            r_err   <= (s_axi_arsize != SIZE_64B) ||
                       (s_axi_arburst == BURST_RSVD);
            r_cnt   <= '0;
            r_state <= R_FETCH;
          end
        end
        R_FETCH: begin
          // old data wins over a same-cycle write
          r_data  <= r_err ? '0 : mem[r_idx];
          r_state <= R_DATA;
        end
        R_DATA: begin
          if (s_axi_rready) begin
            if (r_cnt == r_len) begin
              r_state <= R_IDLE;
            end else begin
              r_cnt   <= r_cnt + 1'b1;
              if (!r_fixed) r_idx <= r_idx + 1'b1;
              r_state <= R_FETCH;
            end
          end
        end
        default: r_state <= R_IDLE;
      endcase
    end
  end

  assign s_axi_awready = w_state == W_IDLE;
  assign s_axi_wready  = w_state == W_DATA;
  assign s_axi_bvalid  = w_state == W_RESP;
  assign s_axi_bresp   = (s_axi_bvalid && w_err) ? RESP_SLVERR : RESP_OKAY;

  assign s_axi_arready = r_state == R_IDLE;
  assign s_axi_rvalid  = r_state == R_DATA;
  assign s_axi_rdata   = r_data;
  assign s_axi_rresp   = (s_axi_rvalid && r_err) ? RESP_SLVERR : RESP_OKAY;
  assign s_axi_rlast   = s_axi_rvalid && (r_cnt == r_len);

  logic unused_ok;
  assign unused_ok = ^{s_axi_awaddr, s_axi_araddr,
                       s_axi_awlock, s_axi_awcache, s_axi_awprot,
                       s_axi_awregion, s_axi_awqos,
                       s_axi_arlock, s_axi_arcache, s_axi_arprot,
                       s_axi_arregion, s_axi_arqos};

endmodule

// File: tb/tb_axi_mem_responder.sv
// Bench for axi_mem_responder: directed bursts against a word-array
// memory model with per-cycle R and B channel comparison.
module tb_axi_mem_responder;

  logic         clk;
  logic         aresetn;
  logic [31:0]  awaddr;
  logic [7:0]   awlen;
  logic [2:0]   awsize;
  logic [1:0]   awburst;
  logic         awlock;
  logic [3:0]   awcache;
  logic [2:0]   awprot;
  logic [3:0]   awregion;
  logic [3:0]   awqos;
  logic         awvalid;
  logic         awready;
  logic [511:0] wdata;
  logic [63:0]  wstrb;
  logic         wlast;
  logic         wvalid;
  logic         wready;
  logic [1:0]   bresp;
  logic         bvalid;
  logic         bready;
  logic [31:0]  araddr;
  logic [7:0]   arlen;
  logic [2:0]   arsize;
  logic [1:0]   arburst;
  logic         arlock;
  logic [3:0]   arcache;
  logic [2:0]   arprot;
  logic [3:0]   arregion;
  logic [3:0]   arqos;
  logic         arvalid;
  logic         arready;
  logic [511:0] rdata;
  logic [1:0]   rresp;
  logic         rlast;
  logic         rvalid;
  logic         rready;

  axi_mem_responder dut (
    .s_axi_aclk     (clk),
    .s_axi_aresetn  (aresetn),
    .s_axi_awaddr   (awaddr),
    .s_axi_awlen    (awlen),
    .s_axi_awsize   (awsize),
    .s_axi_awburst  (awburst),
    .s_axi_awlock   (awlock),
    .s_axi_awcache  (awcache),
    .s_axi_awprot   (awprot),
    .s_axi_awregion (awregion),
    .s_axi_awqos    (awqos),
    .s_axi_awvalid  (awvalid),
    .s_axi_awready  (awready),
    .s_axi_wdata    (wdata),
    .s_axi_wstrb    (wstrb),
    .s_axi_wlast    (wlast),
    .s_axi_wvalid   (wvalid),
    .s_axi_wready   (wready),
    .s_axi_bresp    (bresp),
    .s_axi_bvalid   (bvalid),
    .s_axi_bready   (bready),
    .s_axi_araddr   (araddr),
    .s_axi_arlen    (arlen),
    .s_axi_arsize   (arsize),
    .s_axi_arburst  (arburst),
    .s_axi_arlock   (arlock),
    .s_axi_arcache  (arcache),
    .s_axi_arprot   (arprot),
    .s_axi_arregion (arregion),
    .s_axi_arqos    (arqos),
    .s_axi_arvalid  (arvalid),
    .s_axi_arready  (arready),
    .s_axi_rdata    (rdata),
    .s_axi_rresp    (rresp),
    .s_axi_rlast    (rlast),
    .s_axi_rvalid   (rvalid),
    .s_axi_rready   (rready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [511:0] d;
    logic [1:0]   resp;
    logic         last;
  } rbeat_t;

  logic [511:0] mm [1024];
  rbeat_t       rq [$];
  logic [1:0]   bq [$];
  int           checks;
  int           errors;
  localparam logic [63:0] ALL = '1;

  task automatic chk(input string name, input logic [511:0] act,
                     input logic [511:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic fail(input string name);
    checks++;
    errors++;
    $display("FAIL %s: wait bound expired or unexpected beat", name);
  endtask

  // R and B channels checked every cycle against model queues
  task automatic monitor();
    forever begin
      @(negedge clk);
      if (!aresetn) begin
        rq.delete();
        bq.delete();
      end else begin
        if (rvalid) begin
          chk("r_arready_low", arready, 0);
          if (rq.size() == 0) fail("r_extra_beat");
          else begin
            chk("rdata", rdata, rq[0].d);
            chk("rresp", rresp, rq[0].resp);
            chk("rlast", rlast, rq[0].last);
            if (rready) void'(rq.pop_front());
          end
        end
        if (bvalid) begin
          chk("b_awready_low", awready, 0);
          if (bq.size() == 0) fail("b_extra_resp");
          else begin
            chk("bresp", bresp, bq[0]);
            if (bready) void'(bq.pop_front());
          end
        end
        if (wready) chk("w_awready_low", awready, 0);
      end
    end
  endtask

  task automatic do_write(input logic [31:0] addr, input logic [7:0] len,
                          input logic [2:0] size, input logic [1:0] burst,
                          input int nbeats, input int last_at,
                          input logic [63:0] strb, input logic [31:0] seed,
                          input int bhold);
    logic [9:0]   idx;
    logic         err;
    logic [511:0] d;
    int           n;
    idx = addr[15:6];
    err = (size != 3'b110) || (burst == 2'b11);
    @(posedge clk); #1;
    awaddr = addr; awlen = len; awsize = size; awburst = burst;
    awvalid = 1'b1;
    n = 0;
    @(negedge clk);
    while (!awready && n < 50) begin @(negedge clk); n++; end
    if (!awready) begin fail("aw_timeout"); awvalid = 1'b0; return; end
    @(posedge clk); #1;
    awvalid = 1'b0;
    for (int b = 0; b < nbeats; b++) begin
      d = {16{seed + 32'(b)}};
      wdata = d; wstrb = strb; wlast = (b == last_at); wvalid = 1'b1;
      n = 0;
      @(negedge clk);
      while (!wready && n < 50) begin @(negedge clk); n++; end
      if (!wready) begin fail("w_timeout"); break; end
      if (!err && b <= int'(len))
        for (int i = 0; i < 64; i++)
          if (strb[i]) mm[idx][8*i +: 8] = d[8*i +: 8];
      if (b > int'(len)) err = 1'b1;
      if (burst != 2'b00) idx = idx + 1'b1;
      @(posedge clk); #1;
      if (b == last_at) begin
        if (b != int'(len)) err = 1'b1;
        break;
      end
    end
    wvalid = 1'b0; wlast = 1'b0;
    bq.push_back(err ? 2'b10 : 2'b00);
    n = 0;
    @(negedge clk);
    while (!bvalid && n < 50) begin @(negedge clk); n++; end
    if (!bvalid) begin fail("b_timeout"); return; end
    repeat (bhold) begin
      @(negedge clk);
      chk("b_hold_bvalid", bvalid, 1);
      chk("b_hold_awready", awready, 0);
    end
    @(posedge clk); #1 bready = 1'b1;
    @(negedge clk);
    @(posedge clk); #1 bready = 1'b0;
    @(negedge clk);
    chk("b_done_bvalid", bvalid, 0);
    chk("b_done_awready", awready, 1);
  endtask

  task automatic push_read(input logic [31:0] addr, input logic [7:0] len,
                           input logic [2:0] size, input logic [1:0] burst);
    logic [9:0] idx;
    logic       err;
    rbeat_t     e;
    idx = addr[15:6];
    err = (size != 3'b110) || (burst == 2'b11);
    for (int i = 0; i <= int'(len); i++) begin
      e.d    = err ? '0 : mm[idx];
      e.resp = err ? 2'b10 : 2'b00;
      e.last = (i == int'(len));
      rq.push_back(e);
      if (burst != 2'b00) idx = idx + 1'b1;
    end
  endtask

  task automatic do_read(input logic [31:0] addr, input logic [7:0] len,
                         input logic [2:0] size, input logic [1:0] burst,
                         input int mode);
    int n;
    int k;
    push_read(addr, len, size, burst);
    @(posedge clk); #1;
    araddr = addr; arlen = len; arsize = size; arburst = burst;
    arvalid = 1'b1; rready = 1'b0;
    n = 0;
    @(negedge clk);
    while (!arready && n < 50) begin @(negedge clk); n++; end
    if (!arready) begin fail("ar_timeout"); arvalid = 1'b0; return; end
    @(posedge clk); #1;
    arvalid = 1'b0; rready = 1'b1;
    @(negedge clk);
    chk("r_lat_fetch", rvalid, 0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("r_lat_first", rvalid, 1);
    #1;
    k = 1; n = 0;
    while (rq.size() != 0 && n < 200) begin
      @(posedge clk); #1;
      rready = (mode == 0) || (k % 4 == 0) || (k % 4 == 3);
      k++;
      @(negedge clk); #1;
      n++;
    end
    chk("r_all_beats", rq.size(), 0);
    @(posedge clk); #1 rready = 1'b0;
    @(negedge clk);
    chk("r_done_rvalid", rvalid, 0);
    chk("r_done_arready", arready, 1);
  endtask

  task automatic reset_checks(input string tag);
    chk({tag, "_awready"}, awready, 1);
    chk({tag, "_arready"}, arready, 1);
    chk({tag, "_wready"}, wready, 0);
    chk({tag, "_bvalid"}, bvalid, 0);
    chk({tag, "_rvalid"}, rvalid, 0);
  endtask

  logic [511:0] strb_exp;
  int           n;

  initial begin
    checks = 0; errors = 0;
    aresetn = 1'b0;
    awaddr = '0; awlen = '0; awsize = '0; awburst = '0; awvalid = 1'b0;
    awlock = 1'b0; awcache = '0; awprot = '0; awregion = '0; awqos = '0;
    wdata = '0; wstrb = '0; wlast = 1'b0; wvalid = 1'b0; bready = 1'b0;
    araddr = '0; arlen = '0; arsize = '0; arburst = '0; arvalid = 1'b0;
    arlock = 1'b0; arcache = '0; arprot = '0; arregion = '0; arqos = '0;
    rready = 1'b0;
    fork
      monitor();
      begin
        #2000000;
        $display("FAIL watchdog: simulation did not end");
        $fatal(1);
      end
    join_none

    repeat (3) @(posedge clk);
    #1 aresetn = 1'b1;
    @(negedge clk);
    reset_checks("rst");
    chk("rst_rlast", rlast, 0);
    chk("rst_rdata", rdata, 0);
    chk("rst_bresp", bresp, 0);
    chk("rst_rresp", rresp, 0);

    // write-then-read, 4 INCR beats at word 1
    do_write(32'h40, 8'd3, 3'b110, 2'b01, 4, 3, ALL, 32'hA000_0000, 0);
    chk("pin_w1", mm[1][31:0], 32'hA000_0000);
    chk("pin_w4", mm[4][511:480], 32'hA000_0003);
    do_read(32'h40, 8'd3, 3'b110, 2'b01, 0);

    // byte strobes on word 0
    do_write(32'h0, 8'd0, 3'b110, 2'b01, 1, 0, ALL, 32'hFFFF_FFFF, 0);
    do_write(32'h0, 8'd0, 3'b110, 2'b01, 1, 0, 64'hF0, 32'h0, 0);
    strb_exp = ~(512'hFFFF_FFFF << 32);
    chk("pin_strb", mm[0], strb_exp);
    do_read(32'h0, 8'd0, 3'b110, 2'b01, 0);

    // backpressure on B and R
    do_write(32'h1000, 8'd7, 3'b110, 2'b01, 8, 7, ALL, 32'hB000_0000, 5);
    do_read(32'h1000, 8'd7, 3'b110, 2'b01, 1);

    // error bursts
    do_write(32'h40, 8'd3, 3'b101, 2'b01, 4, 3, ALL, 32'hC000_0000, 0);
    chk("pin_sizeerr", mm[1][31:0], 32'hA000_0000);
    do_read(32'h40, 8'd0, 3'b110, 2'b01, 0);
    do_write(32'h3000, 8'd3, 3'b110, 2'b01, 4, 1, ALL, 32'hD000_0000, 0);
    do_read(32'h3000, 8'd1, 3'b110, 2'b01, 0);
    do_write(32'h4080, 8'd0, 3'b110, 2'b01, 1, 0, ALL, 32'h1111_0000, 0);
    do_write(32'h4000, 8'd1, 3'b110, 2'b01, 3, 2, ALL, 32'hE000_0000, 0);
    chk("pin_late", mm[258][31:0], 32'h1111_0000);
    do_read(32'h4000, 8'd2, 3'b110, 2'b01, 0);
    do_read(32'h40, 8'd2, 3'b110, 2'b11, 0);
    do_read(32'h40, 8'd0, 3'b100, 2'b01, 0);

    // wrap at top of RAM, aliasing, FIXED
    do_write(32'hFFC0, 8'd1, 3'b110, 2'b01, 2, 1, ALL, 32'hF000_0000, 0);
    chk("pin_wrap0", mm[0][31:0], 32'hF000_0001);
    chk("pin_wrap1023", mm[1023][31:0], 32'hF000_0000);
    do_read(32'hFFC0, 8'd1, 3'b110, 2'b01, 0);
    do_read(32'h0001_0040, 8'd0, 3'b110, 2'b01, 0);
    do_write(32'h3200, 8'd3, 3'b110, 2'b00, 4, 3, ALL, 32'h5000_0000, 0);
    chk("pin_fixed", mm[200][31:0], 32'h5000_0003);
    do_read(32'h3200, 8'd2, 3'b110, 2'b00, 0);

    // reset with read stalled in R_DATA and write awaiting beat 2
    push_read(32'h40, 8'd3, 3'b110, 2'b01);
    @(posedge clk); #1;
    araddr = 32'h40; arlen = 8'd3; arsize = 3'b110; arburst = 2'b01;
    arvalid = 1'b1; rready = 1'b0;
    n = 0;
    @(negedge clk);
    while (!arready && n < 50) begin @(negedge clk); n++; end
    @(posedge clk); #1;
    arvalid = 1'b0;
    awaddr = 32'h2000; awlen = 8'd3; awsize = 3'b110; awburst = 2'b01;
    awvalid = 1'b1;
    n = 0;
    @(negedge clk);
    while (!awready && n < 50) begin @(negedge clk); n++; end
    @(posedge clk); #1;
    awvalid = 1'b0;
    wdata = {16{32'h7000_0000}}; wstrb = ALL; wlast = 1'b0; wvalid = 1'b1;
    mm[128] = {16{32'h7000_0000}};
    n = 0;
    @(negedge clk);
    while (!wready && n < 50) begin @(negedge clk); n++; end
    chk("mid_rvalid_before", rvalid, 1);
    chk("mid_wready_before", wready, 1);
    @(posedge clk); #1;
    wvalid = 1'b0;
    aresetn = 1'b0;
    @(posedge clk); #1;
    aresetn = 1'b1;
    @(negedge clk);
    reset_checks("mid");
    do_read(32'h2000, 8'd0, 3'b110, 2'b01, 0);
    do_write(32'h2000, 8'd3, 3'b110, 2'b01, 4, 3, ALL, 32'h8000_0000, 0);
    do_read(32'h2000, 8'd3, 3'b110, 2'b01, 1);

    repeat (3) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
